// File: rtl/modexp_io_buf.sv
// modexp_io_buf: core-side host-link buffer for the 4096-bit ModExp engine.
// Loads five operand word arrays, launches the core, streams the result back.
module modexp_io_buf #(
   parameter int DATA_WIDTH = 64,
   parameter int NUM_WORDS  = 64,
   parameter int IDX_W      = 6
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  startInput,
   input  logic [DATA_WIDTH-1:0] m_buf,
   input  logic [DATA_WIDTH-1:0] e_buf,
   input  logic [DATA_WIDTH-1:0] n_buf,
   input  logic [DATA_WIDTH-1:0] r_buf,
   input  logic [DATA_WIDTH-1:0] t_buf,
   input  logic [63:0]           nprime0,
   input  logic                  startCompute,
   input  logic                  getResult,
   input  logic [IDX_W-1:0]      rd_idx,
   output logic [DATA_WIDTH-1:0] m_word,
   output logic [DATA_WIDTH-1:0] e_word,
   output logic [DATA_WIDTH-1:0] n_word,
   output logic [DATA_WIDTH-1:0] r_word,
   output logic [DATA_WIDTH-1:0] t_word,
   output logic [63:0]           np0,
   output logic                  core_start,
   input  logic                  core_done,
   input  logic                  res_we,
   input  logic [IDX_W-1:0]      res_idx,
   input  logic [DATA_WIDTH-1:0] res_wdata,
   output logic [DATA_WIDTH-1:0] res_out,
   output logic                  res_valid,
   output logic [3:0]            state
);

   typedef enum logic [3:0] {
      S_IDLE = 4'd0,
      S_LOAD = 4'd1,
      S_WAIT = 4'd2,
      S_COMP = 4'd3,
      S_CPLT = 4'd9,
      S_OUT  = 4'd10
   } state_t;

   localparam logic [IDX_W:0] C_LAST = (IDX_W+1)'(NUM_WORDS-1);
   localparam logic [IDX_W:0] C_END  = (IDX_W+1)'(NUM_WORDS);

   state_t                r_state;
   state_t                w_state_nxt;
   logic [IDX_W:0]        r_cnt;
   logic [IDX_W:0]        w_cnt_nxt;
   logic                  w_start;
   logic [IDX_W-1:0]      w_cidx;

   logic [DATA_WIDTH-1:0] r_m   [NUM_WORDS];
   logic [DATA_WIDTH-1:0] r_e   [NUM_WORDS];
   logic [DATA_WIDTH-1:0] r_n   [NUM_WORDS];
   logic [DATA_WIDTH-1:0] r_r   [NUM_WORDS];
   logic [DATA_WIDTH-1:0] r_t   [NUM_WORDS];
   logic [DATA_WIDTH-1:0] r_res [NUM_WORDS];
   logic [63:0]           r_np0;
   logic                  r_core_start;
   logic [DATA_WIDTH-1:0] r_res_out;
   logic                  r_res_valid;

   assign w_cidx = r_cnt[IDX_W-1:0];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_start     = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (startInput) begin
               w_state_nxt = S_LOAD;
               w_cnt_nxt   = '0;
            end
         end
         S_LOAD: begin
            w_cnt_nxt = r_cnt + 1'b1;
            if (r_cnt == C_LAST) begin
               w_state_nxt = S_WAIT;
               w_cnt_nxt   = '0;
            end
         end
         S_WAIT: begin
            if (startCompute) begin
               w_state_nxt = S_COMP;
               w_start     = 1'b1;
            end
         end
         S_COMP: begin
            if (core_done) w_state_nxt = S_CPLT;
         end
         S_CPLT: begin
            if (getResult) begin
               w_state_nxt = S_OUT;
               w_cnt_nxt   = '0;
            end
         end
         S_OUT: begin
            // one extra edge past the last word drops res_valid on IDLE entry
            if (r_cnt == C_END) begin
               w_state_nxt = S_IDLE;
               w_cnt_nxt   = '0;
            end else begin
               w_cnt_nxt = r_cnt + 1'b1;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NUM_WORDS; i++) begin
            r_m[i]   <= '0;
            r_e[i]   <= '0;
            r_n[i]   <= '0;
            r_r[i]   <= '0;
            r_t[i]   <= '0;
            r_res[i] <= '0;
         end
         r_np0        <= '0;
         r_core_start <= 1'b0;
         r_res_out    <= '0;
         r_res_valid  <= 1'b0;
      end else begin
         r_core_start <= w_start;
         if (r_state == S_LOAD) begin
            r_m[w_cidx] <= m_buf;
            r_e[w_cidx] <= e_buf;
            r_n[w_cidx] <= n_buf;
            r_r[w_cidx] <= r_buf;
            r_t[w_cidx] <= t_buf;
            if (r_cnt == '0) r_np0 <= nprime0;
         end
         if (r_state == S_COMP && res_we)
            r_res[res_idx] <= res_wdata;
         if (r_state == S_OUT) begin
            if (r_cnt == C_END) begin
               r_res_valid <= 1'b0;
            end else begin
               r_res_out   <= r_res[w_cidx];
               r_res_valid <= 1'b1;
            end
         end
      end
   end

   assign m_word     = r_m[rd_idx];
   assign e_word     = r_e[rd_idx];
   assign n_word     = r_n[rd_idx];
   assign r_word     = r_r[rd_idx];
   assign t_word     = r_t[rd_idx];
   assign np0        = r_np0;
   assign core_start = r_core_start;
   assign res_out    = r_res_out;
   assign res_valid  = r_res_valid;
   assign state      = r_state;

endmodule

// File: tb/tb_modexp_io_buf.sv
// tb_modexp_io_buf: directed bench for modexp_io_buf.
// Result stream is checked by a queue-fed monitor.
module tb_modexp_io_buf;

   logic        clk = 1'b0;
   logic        reset;
   logic        startInput, startCompute, getResult;
   logic [63:0] m_buf, e_buf, n_buf, r_buf, t_buf, nprime0;
   logic [5:0]  rd_idx;
   logic [63:0] m_word, e_word, n_word, r_word, t_word, np0;
   logic        core_start, core_done, res_we;
   logic [5:0]  res_idx;
   logic [63:0] res_wdata, res_out;
   logic        res_valid;
   logic [3:0]  state;

   int          n_vec = 0;
   int          n_err = 0;
   int          n_valid = 0;
   logic [63:0] q[$];

   always #5 clk = ~clk;

   modexp_io_buf dut (
      .clk(clk), .reset(reset), .startInput(startInput),
      .m_buf(m_buf), .e_buf(e_buf), .n_buf(n_buf),
      .r_buf(r_buf), .t_buf(t_buf), .nprime0(nprime0),
      .startCompute(startCompute), .getResult(getResult),
      .rd_idx(rd_idx),
      .m_word(m_word), .e_word(e_word), .n_word(n_word),
      .r_word(r_word), .t_word(t_word), .np0(np0),
      .core_start(core_start), .core_done(core_done),
      .res_we(res_we), .res_idx(res_idx), .res_wdata(res_wdata),
      .res_out(res_out), .res_valid(res_valid), .state(state)
   );

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // monitor: every valid result word must match the queue head
   always @(negedge clk) begin
      if (reset === 1'b0 && res_valid === 1'b1) begin
         n_valid++;
         if (q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL res_extra: got %h expected no word", res_out);
         end else begin
            chk($sformatf("res_word%0d", n_valid - 1), res_out, q.pop_front());
         end
      end
   end

   task automatic do_load(input logic [63:0] m0, e0, n0, np,
                          input int rst_at, input int sc_at);
      @(negedge clk);
      startInput = 1'b1;
      @(negedge clk);
      for (int k = 0; k < 64; k++) begin
         if (k > 0) @(negedge clk);
         startInput   = 1'b0;
         m_buf        = (k == 0) ? m0 : ((k == 63) ? 64'hDEAD : 64'd0);
         e_buf        = (k == 0) ? e0 : 64'd0;
         n_buf        = (k == 0) ? n0 : 64'd0;
         r_buf        = (k == 0) ? 64'd5 : 64'd0;
         t_buf        = (k == 0) ? 64'd9 : 64'd0;
         nprime0      = (k == 0) ? np : 64'hFFFF;
         startCompute = (k == sc_at);
         if (k == 10) chk("load_state", {60'd0, state}, 64'd1);
         if (k == rst_at) begin
            #2 reset = 1'b1;
            @(negedge clk);
            reset = 1'b0;
            return;
         end
      end
      @(negedge clk);
      m_buf = '0; e_buf = '0; n_buf = '0;
      r_buf = '0; t_buf = '0; nprime0 = '0;
      startCompute = 1'b0;
   endtask

   initial begin
      int cs_cnt;
      int tmo;
      reset = 1'b1;
      startInput = 0; startCompute = 0; getResult = 0;
      m_buf = 0; e_buf = 0; n_buf = 0; r_buf = 0; t_buf = 0;
      nprime0 = 0; rd_idx = 0; core_done = 0; res_we = 0;
      res_idx = 0; res_wdata = 0;
      repeat (2) @(negedge clk);
      reset = 1'b0;

      // async reset mid-cycle out of LOAD
      @(negedge clk); startInput = 1'b1;
      @(negedge clk); startInput = 1'b0;
      chk("enter_load", {60'd0, state}, 64'd1);
      @(posedge clk); #3 reset = 1'b1;
      #1;
      chk("rst_state", {60'd0, state}, 64'd0);
      chk("rst_core_start", {63'd0, core_start}, 64'd0);
      chk("rst_res_valid", {63'd0, res_valid}, 64'd0);
      chk("rst_res_out", res_out, 64'd0);
      @(negedge clk); reset = 1'b0;

      // startCompute in IDLE is ignored
      startCompute = 1'b1;
      repeat (3) @(negedge clk);
      chk("idle_sc_ignored", {60'd0, state}, 64'd0);
      startCompute = 1'b0;

      do_load(64'd8, 64'd13, 64'd77, 64'h1234, -1, 5);
      #1;
      chk("load_done_state", {60'd0, state}, 64'd2);
      rd_idx = 0; #1;
      chk("m0", m_word, 64'd8);
      chk("e0", e_word, 64'd13);
      chk("n0", n_word, 64'd77);
      chk("r0", r_word, 64'd5);
      chk("t0", t_word, 64'd9);
      chk("np0", np0, 64'h1234);
      rd_idx = 1; #1;
      chk("m1", m_word, 64'd0);
      chk("e1", e_word, 64'd0);
      chk("n1", n_word, 64'd0);
      rd_idx = 63; #1;
      chk("m63", m_word, 64'hDEAD);

      // res_we and getResult in WAIT are ignored
      @(negedge clk);
      res_we = 1'b1; res_idx = 3; res_wdata = 64'd77; getResult = 1'b1;
      @(negedge clk);
      res_we = 1'b0; getResult = 1'b0;
      chk("wait_hold", {60'd0, state}, 64'd2);

      // startCompute held: single start pulse
      startCompute = 1'b1;
      cs_cnt = 0;
      repeat (6) begin
         @(negedge clk);
         if (core_start) cs_cnt++;
      end
      startCompute = 1'b0;
      chk("core_start_pulses", 64'(cs_cnt), 64'd1);
      chk("compute_state", {60'd0, state}, 64'd3);

      // core model writes two words, done on the last write edge
      for (int k = 0; k < 64; k++)
         q.push_back(k == 0 ? 64'd50 : (k == 63 ? 64'hA5 : 64'd0));
      res_we = 1'b1; res_idx = 0; res_wdata = 64'd50;
      @(negedge clk);
      res_idx = 63; res_wdata = 64'hA5; core_done = 1'b1;
      @(negedge clk);
      res_we = 1'b0; core_done = 1'b0;
      #1;
      chk("complete_state", {60'd0, state}, 64'd9);
      chk("complete_no_valid", {63'd0, res_valid}, 64'd0);

      // stream the result, getResult held high throughout
      getResult = 1'b1;
      tmo = 0;
      while (q.size() != 0 && tmo < 200) begin
         @(negedge clk); #2;
         tmo++;
      end
      chk("stream_timeout", 64'(q.size()), 64'd0);
      tmo = 0;
      while (state != 4'd0 && tmo < 4) begin
         @(negedge clk); #2;
         tmo++;
      end
      chk("out_idle_state", {60'd0, state}, 64'd0);
      chk("out_valid_low", {63'd0, res_valid}, 64'd0);
      chk("out_hold_last", res_out, 64'hA5);
      chk("valid_cycles", 64'(n_valid), 64'd64);
      getResult = 1'b0;
      @(negedge clk);
      chk("no_reload", {60'd0, state}, 64'd0);

      // reset during load word 30
      do_load(64'd3, 64'd4, 64'd5, 64'd7, 30, -1);
      #1;
      chk("abort_state", {60'd0, state}, 64'd0);
      rd_idx = 0; #1;
      chk("abort_m0", m_word, 64'd0);
      chk("abort_np0", np0, 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
